// File: rtl/nettlp_tx_sched_pkg.sv
// Shared types for the Ethernet TX encapsulation scheduler: source encoding, request vectors, FSM states.
package nettlp_sched_pkg;

    localparam int SCHED_NSRC = 3;

    typedef enum logic [1:0] {
        SRC_TLP     = 2'd0,
        SRC_CMD     = 2'd1,
        SRC_PCIECFG = 2'd2
    } SCHED_SRC_T;

    typedef logic [SCHED_NSRC-1:0] SCHED_VEC_T;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } sched_state_t;

    // Sources that the starvation guard protects from a continuous TLP stream.
    localparam SCHED_VEC_T SCHED_OTHERS_MASK = 3'b110;

    function automatic SCHED_VEC_T src_bit(SCHED_SRC_T s);
        return SCHED_VEC_T'(1) << s;
    endfunction

endpackage

// File: rtl/nettlp_tx_sched_if.sv
// Request/grant bundle between the source FIFOs, the encap datapath and the TX scheduler.
interface nettlp_tx_sched_if;
    import nettlp_sched_pkg::*;

    SCHED_VEC_T req;
    logic       pkt_done;
    SCHED_VEC_T gnt;
    logic       gnt_valid;
    logic       timeout_o;
    logic       starve_o;

    modport master (
        input  req, pkt_done,
        output gnt, gnt_valid, timeout_o, starve_o
    );

    modport slave (
        output req, pkt_done,
        input  gnt, gnt_valid, timeout_o, starve_o
    );
endinterface

// File: rtl/nettlp_tx_sched_prio_pick.sv
// Combinational lowest-set-bit picker over (vec & mask); zero latency, no backpressure.
module nettlp_prio_pick
    import nettlp_sched_pkg::*;
(
    input  SCHED_VEC_T vec,
    input  SCHED_VEC_T mask,
    output SCHED_VEC_T onehot
);

    SCHED_VEC_T masked;

    always_comb begin
        masked = vec & mask;
        // Two's-complement trick isolates the lowest set bit.
        onehot = masked & (~masked + SCHED_VEC_T'(1));
    end

endmodule

// File: rtl/nettlp_tx_sched.sv
// Fixed-priority TX packet scheduler (TLP > CMD > PCIECFG) with starvation guard and grant watchdog.
// Grant 1 cycle after req, held to pkt_done, then one gap cycle; NETTLP_TX_SCHED_STATS_EN adds counters.
module nettlp_tx_sched
    import nettlp_sched_pkg::*;
#(
    parameter int unsigned STARVE_MAX  = 8,
    parameter logic [15:0] TIMEOUT_CYC = 16'd4096
) (
    input  logic eth_clk,
    input  logic eth_rst,
    nettlp_tx_sched_if.master bus
`ifdef NETTLP_TX_SCHED_STATS_EN
    ,
    input  logic                         stat_clr,
    output logic [SCHED_NSRC-1:0][31:0]  stat_gnt_cnt,
    output logic [15:0]                  stat_timeout_cnt
`endif
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    sched_state_t state_q, state_d;
    SCHED_VEC_T   gnt_q, gnt_d;
    logic         gnt_valid_q, gnt_valid_d;
    logic         timeout_q, timeout_d;
    logic         starve_q, starve_d;
    logic [7:0]   starve_cnt_q, starve_cnt_d;
    logic [15:0]  wd_cnt_q, wd_cnt_d;

    SCHED_VEC_T pick_all;
    SCHED_VEC_T pick_oth;
    SCHED_VEC_T winner;
    logic       others_pend;
    logic       force_oth;
    logic       wd_expire;

    nettlp_prio_pick u_pick_all (
        .vec    (bus.req),
        .mask   ({SCHED_NSRC{1'b1}}),
        .onehot (pick_all)
    );

    nettlp_prio_pick u_pick_oth (
        .vec    (bus.req),
        .mask   (SCHED_OTHERS_MASK),
        .onehot (pick_oth)
    );

    always_comb begin
        others_pend = |(bus.req & SCHED_OTHERS_MASK);
        force_oth   = (starve_cnt_q == STARVE_LIM) && others_pend;
        winner      = force_oth ? pick_oth : pick_all;
        wd_expire   = (TIMEOUT_CYC != 16'd0) && (wd_cnt_q == TIMEOUT_CYC - 16'd1);
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        gnt_valid_d  = gnt_valid_q;
        timeout_d    = 1'b0;
        starve_d     = 1'b0;
        starve_cnt_d = starve_cnt_q;
        wd_cnt_d     = wd_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (|bus.req) begin
                    state_d     = S_GRANT;
                    gnt_d       = winner;
                    gnt_valid_d = 1'b1;
                    starve_d    = force_oth;
                    wd_cnt_d    = 16'd0;
                    // Only a TLP win over a waiting CMD/PCIECFG counts toward starvation.
                    if ((winner == src_bit(SRC_TLP)) && others_pend) begin
                        if (starve_cnt_q != STARVE_LIM) begin
                            starve_cnt_d = starve_cnt_q + 8'd1;
                        end
                    end else begin
                        starve_cnt_d = 8'd0;
                    end
                end
            end

            S_GRANT: begin
                if (bus.pkt_done) begin
                    state_d     = S_GAP;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    wd_cnt_d    = 16'd0;
                end else if (wd_expire) begin
                    state_d     = S_GAP;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    timeout_d   = 1'b1;
                    wd_cnt_d    = 16'd0;
                end else begin
                    wd_cnt_d = wd_cnt_q + 16'd1;
                end
            end

            // One dead cycle lets the encap datapath latch the next header.
            S_GAP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d      = S_IDLE;
                gnt_d        = '0;
                gnt_valid_d  = 1'b0;
                starve_cnt_d = 8'd0;
                wd_cnt_d     = 16'd0;
            end
        endcase
    end

    always_ff @(posedge eth_clk) begin
        if (eth_rst) begin
            state_q      <= S_IDLE;
            gnt_q        <= '0;
            gnt_valid_q  <= 1'b0;
            timeout_q    <= 1'b0;
            starve_q     <= 1'b0;
            starve_cnt_q <= 8'd0;
            wd_cnt_q     <= 16'd0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            gnt_valid_q  <= gnt_valid_d;
            timeout_q    <= timeout_d;
            starve_q     <= starve_d;
            starve_cnt_q <= starve_cnt_d;
            wd_cnt_q     <= wd_cnt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout_o = timeout_q;
    assign bus.starve_o  = starve_q;

`ifdef NETTLP_TX_SCHED_STATS_EN
    logic [SCHED_NSRC-1:0][31:0] stat_gnt_q, stat_gnt_d;
    logic [15:0]                 stat_to_q, stat_to_d;

    always_comb begin
        stat_gnt_d = stat_gnt_q;
        stat_to_d  = stat_to_q;
        if (stat_clr) begin
            stat_gnt_d = '0;
            stat_to_d  = '0;
        end else begin
            for (int i = 0; i < SCHED_NSRC; i++) begin
                if ((state_q == S_IDLE) && gnt_valid_d && gnt_d[i]) begin
                    stat_gnt_d[i] = stat_gnt_q[i] + 32'd1;
                end
            end
            if (timeout_d && (stat_to_q != 16'hFFFF)) begin
                stat_to_d = stat_to_q + 16'd1;
            end
        end
    end

    always_ff @(posedge eth_clk) begin
        if (eth_rst) begin
            stat_gnt_q <= '0;
            stat_to_q  <= '0;
        end else begin
            stat_gnt_q <= stat_gnt_d;
            stat_to_q  <= stat_to_d;
        end
    end

    assign stat_gnt_cnt     = stat_gnt_q;
    assign stat_timeout_cnt = stat_to_q;
`endif

endmodule

// File: tb/tb_nettlp_tx_sched.sv
// Directed bench for nettlp_tx_sched: packet-level reference model compared every cycle plus literal pins.
module tb_nettlp_tx_sched;
    import nettlp_sched_pkg::*;

    localparam int SMAX = 2;
    localparam int TOUT = 16;

    logic eth_clk = 1'b0;
    logic eth_rst = 1'b1;
    logic chk_en  = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    always #5 eth_clk = ~eth_clk;

    nettlp_tx_sched_if bus ();

`ifdef NETTLP_TX_SCHED_STATS_EN
    logic                        stat_clr = 1'b0;
    logic [SCHED_NSRC-1:0][31:0] stat_gnt_cnt;
    logic [15:0]                 stat_timeout_cnt;
`endif

    nettlp_tx_sched #(
        .STARVE_MAX  (SMAX),
        .TIMEOUT_CYC (16'(TOUT))
    ) dut (
        .eth_clk (eth_clk),
        .eth_rst (eth_rst),
        .bus     (bus)
`ifdef NETTLP_TX_SCHED_STATS_EN
        ,
        .stat_clr         (stat_clr),
        .stat_gnt_cnt     (stat_gnt_cnt),
        .stat_timeout_cnt (stat_timeout_cnt)
`endif
    );

    // Reference model: packet ownership, grant age and TLP streak length.
    int         m_phase;   // 0 free, 1 owned, 2 gap
    int         m_len;
    int         m_streak;
    int         m_w;
    bit         m_oth;
    SCHED_VEC_T m_gnt;
    logic       m_vld, m_to, m_st;
`ifdef NETTLP_TX_SCHED_STATS_EN
    logic [31:0] m_cnt [3];
    logic [15:0] m_tcnt;
    bit          m_new;
`endif

    always @(posedge eth_clk) begin
        m_to = 1'b0;
        m_st = 1'b0;
`ifdef NETTLP_TX_SCHED_STATS_EN
        m_new = 1'b0;
`endif
        if (eth_rst) begin
            m_phase = 0; m_len = 0; m_streak = 0;
            m_gnt = '0; m_vld = 1'b0;
        end else begin
            case (m_phase)
                0: if (bus.req != 3'b000) begin
                    m_oth = bus.req[1] | bus.req[2];
                    if (m_streak == SMAX && m_oth) begin
                        m_w  = bus.req[1] ? 1 : 2;
                        m_st = 1'b1;
                    end else begin
                        m_w = bus.req[0] ? 0 : (bus.req[1] ? 1 : 2);
                    end
                    m_streak = (m_w == 0 && m_oth) ? m_streak + 1 : 0;
                    m_gnt    = SCHED_VEC_T'(1 << m_w);
                    m_vld    = 1'b1;
                    m_len    = 0;
                    m_phase  = 1;
`ifdef NETTLP_TX_SCHED_STATS_EN
                    m_new = 1'b1;
`endif
                end
                1: begin
                    m_len++;
                    if (bus.pkt_done || m_len == TOUT) begin
                        m_to    = !bus.pkt_done;
                        m_gnt   = '0;
                        m_vld   = 1'b0;
                        m_phase = 2;
                    end
                end
                default: m_phase = 0;
            endcase
        end
`ifdef NETTLP_TX_SCHED_STATS_EN
        if (eth_rst || stat_clr) begin
            for (int i = 0; i < 3; i++) m_cnt[i] = '0;
            m_tcnt = '0;
        end else begin
            if (m_new) m_cnt[m_w] = m_cnt[m_w] + 32'd1;
            if (m_to && m_tcnt != 16'hFFFF) m_tcnt = m_tcnt + 16'd1;
        end
`endif
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge eth_clk);
        #1;
    endtask

    task automatic wait_gnt(output SCHED_VEC_T g);
        int n = 0;
        while (!bus.gnt_valid && n < 50) begin
            tick();
            n++;
        end
        check("gnt_wait", 128'(bus.gnt_valid), 128'(1'b1));
        g = bus.gnt;
    endtask

    // Grant is in its first cycle on entry; pkt_done lands in cycle len.
    task automatic finish_pkt(input int len, input SCHED_VEC_T req_after);
        repeat (len - 1) tick();
        bus.pkt_done = 1'b1;
        bus.req      = req_after;
        tick();
        bus.pkt_done = 1'b0;
        check("release", 128'(bus.gnt_valid), 128'(1'b0));
    endtask

    SCHED_VEC_T g;
    SCHED_VEC_T seq_exp [6];
    int         n;

    initial begin
        bus.req      = '0;
        bus.pkt_done = 1'b0;
        seq_exp = '{3'b001, 3'b001, 3'b010, 3'b001, 3'b001, 3'b010};

        fork
            forever begin
                @(negedge eth_clk);
                if (chk_en) begin
                    check("cycle", 128'({bus.gnt, bus.gnt_valid, bus.timeout_o, bus.starve_o}),
                                   128'({m_gnt, m_vld, m_to, m_st}));
`ifdef NETTLP_TX_SCHED_STATS_EN
                    check("stats", 128'({stat_timeout_cnt, stat_gnt_cnt}),
                                   128'({m_tcnt, m_cnt[2], m_cnt[1], m_cnt[0]}));
`endif
                end
            end
        join_none

        tick();
        chk_en = 1'b1;
        check("reset_state", 128'({bus.gnt, bus.gnt_valid, bus.timeout_o, bus.starve_o}), 128'(0));
        tick();
        eth_rst = 1'b0;
        tick();

        // Single TLP packet, 10 grant cycles.
        bus.req = 3'b001;
        tick();
        check("t1_gnt_cycle1", 128'({bus.gnt, bus.gnt_valid}), 128'(4'b0011));
        finish_pkt(10, 3'b000);
        check("t1_no_pulse", 128'({bus.timeout_o, bus.starve_o}), 128'(2'b00));
        tick();
        check("t1_idle", 128'(bus.gnt), 128'(3'b000));

        // All sources pending: starvation guard forces CMD every third grant.
        bus.req = 3'b111;
        for (int i = 0; i < 6; i++) begin
            wait_gnt(g);
            check($sformatf("t2_seq%0d", i), 128'(g), 128'(seq_exp[i]));
            check($sformatf("t2_starve%0d", i), 128'(bus.starve_o), 128'(i == 2 || i == 5));
            finish_pkt(2, (i == 5) ? 3'b000 : 3'b111);
        end
        tick();

        // PCIECFG grant is committed even when TLP arrives mid-packet.
        bus.req = 3'b100;
        wait_gnt(g);
        check("t3_cfg", 128'(g), 128'(3'b100));
        bus.req = 3'b101;
        finish_pkt(4, 3'b001);
        wait_gnt(g);
        check("t3_tlp_next", 128'(g), 128'(3'b001));
        check("t3_no_starve", 128'(bus.starve_o), 128'(1'b0));
        finish_pkt(1, 3'b000);
        tick();

        // Watchdog: no pkt_done, grant revoked after 16 cycles, then re-granted.
        bus.req = 3'b001;
        wait_gnt(g);
        n = 0;
        while (bus.gnt_valid && n < 40) begin
            n++;
            tick();
        end
        check("t4_grant_len", 128'(n), 128'(16));
        check("t4_timeout_pulse", 128'(bus.timeout_o), 128'(1'b1));
        tick();
        check("t4_timeout_one", 128'(bus.timeout_o), 128'(1'b0));
        wait_gnt(g);
        check("t4_regrant", 128'(g), 128'(3'b001));
        finish_pkt(1, 3'b000);
        tick();

        // pkt_done on the watchdog's last cycle wins.
        bus.req = 3'b001;
        wait_gnt(g);
        finish_pkt(16, 3'b000);
        check("t5_tie_no_timeout", 128'(bus.timeout_o), 128'(1'b0));
        tick();

        // Reset in the middle of a grant.
        bus.req = 3'b001;
        wait_gnt(g);
        tick();
        tick();
        eth_rst = 1'b1;
        tick();
        check("t5_rst_abort", 128'({bus.gnt, bus.gnt_valid, bus.timeout_o}), 128'(0));
        eth_rst = 1'b0;
        bus.req = 3'b000;
        tick();

`ifdef NETTLP_TX_SCHED_STATS_EN
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.req = (i < 5) ? 3'b001 : 3'b010;
            wait_gnt(g);
            finish_pkt(1, 3'b000);
            tick();
        end
        check("s_tlp", 128'(stat_gnt_cnt[0]), 128'(5));
        check("s_cmd", 128'(stat_gnt_cnt[1]), 128'(3));
        check("s_cfg", 128'(stat_gnt_cnt[2]), 128'(0));
        bus.req  = 3'b001;
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check("s_clr_prio", 128'({stat_timeout_cnt, stat_gnt_cnt}), 128'(0));
        finish_pkt(1, 3'b000);
        tick();
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
